// File: rtl/if_stage.sv
// Instruction-fetch stage of the LoongArch32 5-stage pipeline.
// Owns the fetch PC and the next-PC mux. Issues requests to a 1-cycle-latency
// synchronous instruction SRAM. Parks the returned word while ID is stalled,
// and drives the IF/ID pipeline register feeding the decoder.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stallD,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  output logic [31:0] instD,
  output logic [31:0] pcD,
  output logic        validD
);

  // State encoding is {fs_valid, buf_valid}, so each flag is a plain state bit.
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_LIVE  = 2'b10,
    S_HELD  = 2'b11
  } fs_state_e;

  fs_state_e   state_q, state_d;

  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        req_q;

  logic [31:0] instD_q, instD_d;
  logic [31:0] pcD_q, pcD_d;
  logic        validD_q, validD_d;

  logic        fs_valid;
  logic        buf_valid;
  logic        redirect;
  logic        fs_allowin;
  logic [31:0] seq_pc;
  logic [31:0] nextpc_raw;
  logic [31:0] nextpc;
  logic [31:0] fs_inst;

  assign fs_valid   = state_q[1];
  assign buf_valid  = state_q[0];

  // A redirect seen during a stall is dropped; the hazard unit re-presents it.
  assign redirect   = br_taken & ~stallD;
  assign fs_allowin = ~fs_valid | ~stallD;

  assign seq_pc     = pc_f_q + 32'd4;
  assign nextpc_raw = redirect ? br_target : seq_pc;
  // Misaligned targets are silently word-aligned rather than trapping.
  assign nextpc     = nextpc_raw & 32'hffff_fffc;

  assign inst_sram_en    = resetn & fs_allowin;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_we    = 4'b0000;
  assign inst_sram_wdata = 32'h0;

  // SRAM data is only trusted the cycle after a request, so a stalled word
  // must be served from the buffer.
  assign fs_inst = buf_valid ? inst_buf_q : inst_sram_rdata;

  assign instD  = instD_q;
  assign pcD    = pcD_q;
  assign validD = validD_q;

  // Fetch-slot state register: EMPTY after reset, LIVE or HELD afterwards.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Fetch-slot next state and word capture into the stall buffer.
  always_comb begin
    state_d    = state_q;
    inst_buf_d = inst_buf_q;
    case (state_q)
      S_EMPTY: begin
        if (fs_allowin) begin
          state_d = S_LIVE;
        end
      end
      S_LIVE: begin
        if (!stallD) begin
          state_d = S_LIVE;
        end else if (req_q) begin
          state_d    = S_HELD;
          inst_buf_d = inst_sram_rdata;
        end
      end
      S_HELD: begin
        if (!stallD) begin
          state_d = S_LIVE;
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
  end

  // PC advances whenever the fetch slot can take a new instruction.
  always_comb begin
    pc_f_d = pc_f_q;
    if (fs_allowin) begin
      pc_f_d = nextpc;
    end
  end

  // IF/ID register: hold on stall, squash on redirect, else pass IF through.
  always_comb begin
    instD_d  = instD_q;
    pcD_d    = pcD_q;
    validD_d = validD_q;
    if (!stallD) begin
      pcD_d = pc_f_q;
      if (redirect) begin
        validD_d = 1'b0;
        instD_d  = 32'h0;
      end else begin
        validD_d = fs_valid;
        instD_d  = fs_inst;
      end
    end
  end

  // Datapath registers; reset also drops any in-flight SRAM request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_f_q     <= RESET_PC - 32'd4;
      inst_buf_q <= 32'h0;
      req_q      <= 1'b0;
      instD_q    <= 32'h0;
      pcD_q      <= 32'h0;
      validD_q   <= 1'b0;
    end else begin
      pc_f_q     <= pc_f_d;
      inst_buf_q <= inst_buf_d;
      req_q      <= inst_sram_en;
      instD_q    <= instD_d;
      pcD_q      <= pcD_d;
      validD_q   <= validD_d;
    end
  end

  // Fetch addresses are always word aligned.
  a_addr_aligned: assert property (@(posedge clk) disable iff (!resetn)
    inst_sram_addr[1:0] == 2'b00);

  // No new request may be issued while a valid instruction is stalled in IF.
  a_no_req_in_stall: assert property (@(posedge clk) disable iff (!resetn)
    (fs_valid && stallD) |-> !inst_sram_en);

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vector table, hand-written
// reset sequences, then randomized traffic against a transaction-level model.
module tb_if_stage;

  localparam logic [31:0] R = 32'h1c000000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        stallD = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata = 32'h0;
  logic [31:0] instD;
  logic [31:0] pcD;
  logic        validD;

  int n_vec = 0;
  int n_err = 0;

  if_stage #(.RESET_PC(R)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .stallD          (stallD),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .instD           (instD),
    .pcD             (pcD),
    .validD          (validD)
  );

  always #5 clk = ~clk;

  // Program image: every word address maps to a distinct pseudo-random word.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h2545f491) ^ 32'h5a5ac3c3;
  endfunction

  // 1-cycle SRAM; output is garbage on cycles without a request.
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= memf(inst_sram_addr);
    else              inst_sram_rdata <= $urandom();
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        en;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[16];

  // Behavioural model state
  logic        m_have;
  logic [31:0] m_ifpc;
  logic        m_vld;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic        m_known;

  initial begin
    // stall br  target           en  addr            vld pcD
    tbl[0]  = '{0, 0, 32'h0,        1, R,             0, R - 32'd4};
    tbl[1]  = '{0, 0, 32'h0,        1, R + 32'h4,     1, R};
    tbl[2]  = '{0, 0, 32'h0,        1, R + 32'h8,     1, R + 32'h4};
    tbl[3]  = '{1, 0, 32'h0,        0, R + 32'hc,     1, R + 32'h4};
    tbl[4]  = '{1, 0, 32'h0,        0, R + 32'hc,     1, R + 32'h4};
    tbl[5]  = '{1, 1, 32'h1c000100, 0, R + 32'hc,     1, R + 32'h4};
    tbl[6]  = '{0, 1, 32'h1c000100, 1, 32'h1c000100,  0, R + 32'h8};
    tbl[7]  = '{0, 0, 32'h0,        1, 32'h1c000104,  1, 32'h1c000100};
    tbl[8]  = '{0, 0, 32'h0,        1, 32'h1c000108,  1, 32'h1c000104};
    tbl[9]  = '{0, 1, 32'h1c000203, 1, 32'h1c000200,  0, 32'h1c000108};
    tbl[10] = '{0, 0, 32'h0,        1, 32'h1c000204,  1, 32'h1c000200};
    tbl[11] = '{1, 0, 32'h0,        0, 32'h1c000208,  1, 32'h1c000200};
    tbl[12] = '{0, 0, 32'h0,        1, 32'h1c000208,  1, 32'h1c000204};
    tbl[13] = '{0, 1, 32'hfffffffc, 1, 32'hfffffffc,  0, 32'h1c000208};
    tbl[14] = '{0, 0, 32'h0,        1, 32'h00000000,  1, 32'hfffffffc};
    tbl[15] = '{0, 0, 32'h0,        1, 32'h00000004,  1, 32'h00000000};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_en",     {31'b0, inst_sram_en}, 32'h0);
    chk("rst_validD", {31'b0, validD}, 32'h0);
    chk("rst_instD",  instD, 32'h0);
    chk("rst_pcD",    pcD, 32'h0);
    chk("rst_we",     {28'b0, inst_sram_we}, 32'h0);
    chk("rst_wdata",  inst_sram_wdata, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    // Directed table (each row starts at a negedge)
    for (int i = 0; i < 16; i++) begin
      stallD = tbl[i].stall; br_taken = tbl[i].br; br_target = tbl[i].tgt;
      #1;
      chk($sformatf("tbl%0d_en", i),   {31'b0, inst_sram_en}, {31'b0, tbl[i].en});
      chk($sformatf("tbl%0d_addr", i), inst_sram_addr, tbl[i].addr);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_validD", i), {31'b0, validD}, {31'b0, tbl[i].vld});
      chk($sformatf("tbl%0d_pcD", i),    pcD, tbl[i].pc);
      if (tbl[i].vld)
        chk($sformatf("tbl%0d_instD", i), instD, memf(tbl[i].pc));
      else if (tbl[i].br && !tbl[i].stall)
        chk($sformatf("tbl%0d_instD_sq", i), instD, 32'h0);
      @(negedge clk);
    end

    // Asynchronous reset between edges, mid-stream
    stallD = 1'b0; br_taken = 1'b0;
    @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    chk("arst_validD", {31'b0, validD}, 32'h0);
    chk("arst_instD",  instD, 32'h0);
    chk("arst_pcD",    pcD, 32'h0);
    chk("arst_en",     {31'b0, inst_sram_en}, 32'h0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("restart_en",   {31'b0, inst_sram_en}, 32'h1);
    chk("restart_addr", inst_sram_addr, R);
    @(negedge clk); #1;
    chk("restart_addr2", inst_sram_addr, R + 32'h4);
    @(posedge clk); #1;
    chk("restart_validD", {31'b0, validD}, 32'h1);
    chk("restart_pcD",    pcD, R);
    chk("restart_instD",  instD, memf(R));

    // Randomized traffic from a clean reset
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    m_have = 1'b0; m_ifpc = R - 32'd4;
    m_vld = 1'b0; m_pc = 32'h0; m_inst = 32'h0; m_known = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      logic s, b, redir, acc;
      logic [31:0] tgt, eaddr;
      s = ($urandom_range(0, 99) < 30);
      b = ($urandom_range(0, 99) < 20);
      if ($urandom_range(0, 3) == 0) tgt = $urandom();
      else tgt = {R[31:12], 12'($urandom())};
      stallD = s; br_taken = b; br_target = tgt;
      #1;
      redir = b && !s;
      acc   = !m_have || !s;
      eaddr = redir ? (tgt & 32'hfffffffc) : (m_ifpc + 32'd4);
      chk("rnd_en",   {31'b0, inst_sram_en}, {31'b0, acc});
      chk("rnd_addr", inst_sram_addr, eaddr);
      if (!s) begin
        m_pc = m_ifpc;
        if (redir) begin
          m_vld = 1'b0; m_inst = 32'h0; m_known = 1'b1;
        end else begin
          m_vld = m_have; m_inst = memf(m_ifpc); m_known = m_have;
        end
      end
      if (acc) begin
        m_ifpc = eaddr; m_have = 1'b1;
      end
      @(posedge clk); #1;
      chk("rnd_validD", {31'b0, validD}, {31'b0, m_vld});
      chk("rnd_pcD",    pcD, m_pc);
      if (m_known) chk("rnd_instD", instD, m_inst);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
